rxdeframer: RTL

Parametrised receive deframer for the USRT receive path, clocked entirely from the peripheral clock. It detects a start bit, samples a frame of programmable length on bit-clock falling edges, checks framing (and optionally parity), and delivers each frame through a one-entry valid/ready holding register with overrun detection. It sits between the pin-side synchroniser and the receive FIFO/controller.

---
 rtl/rxdeframer_pkg.sv | 24 ++
 rtl/rxdeframer_bclk_edge.sv | 21 ++
 rtl/rxdeframer.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/rxdeframer_pkg.sv
// Shared types and helpers for the USRT receive deframer.
// Optional parity checking in the top is enabled by RXDEFRAMER_PARITY_EN.
package rxdeframer_pkg;

   localparam int unsigned DEF_MAX_BITS = 11;
   localparam int unsigned DEF_CNT_W    = 4;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      RECV   = 2'd1,
      COMMIT = 2'd2
   } state_t;

   // Frames shorter than start+stop, or longer than the shift register, are clamped.
   function automatic int unsigned clamp_count(input int unsigned count,
                                               input int unsigned max_bits);
      if (count < 2)
         return 2;
      else if (count > max_bits)
         return max_bits;
      return count;
   endfunction

endpackage

// File: rtl/rxdeframer_bclk_edge.sv
// Bit-clock falling-edge detector; i_Bclk is already synchronous to i_Pclk.
// Produces a single-cycle pulse on the i_Pclk cycle after i_Bclk goes low.
module bclk_edge (
   input  logic i_Pclk,
   input  logic i_Reset,
   input  logic i_Bclk,
   output logic o_Fall
);

   logic r_Bclk_d;

   always_ff @(posedge i_Pclk) begin
      if (i_Reset)
         r_Bclk_d <= 1'b0;
      else
         r_Bclk_d <= i_Bclk;
   end

   assign o_Fall = ~i_Bclk & r_Bclk_d;

endmodule

// File: rtl/rxdeframer.sv
// USRT receive deframer: start detect, bit sampling on bit-clock falls, one-entry holding register.
// Parity checking and its ports exist only when RXDEFRAMER_PARITY_EN is defined.
//
// state  | meaning
// IDLE   | waiting for i_Enable with a low level on i_Rx_Serial
// RECV   | sampling one bit per bit-clock fall into the shift register
// COMMIT | one cycle: load holding register or flag overrun
module rxdeframer
   import rxdeframer_pkg::*;
#(
   parameter int unsigned MAX_BITS = DEF_MAX_BITS,
   parameter int unsigned CNT_W    = DEF_CNT_W
) (
   input  logic                i_Pclk,
   input  logic                i_Reset,
   input  logic                i_Enable,
   input  logic                i_Bclk,
   input  logic [CNT_W-1:0]    i_Count,
   input  logic                i_Rx_Serial,
`ifdef RXDEFRAMER_PARITY_EN
   input  logic                i_Parity_Odd,
`endif
   input  logic                i_Ready,
   output logic                o_Valid,
   output logic [MAX_BITS-1:0] o_Data,
   output logic                o_Frame_Err,
`ifdef RXDEFRAMER_PARITY_EN
   output logic                o_Parity_Err,
`endif
   output logic                o_Overrun,
   output logic                o_Busy
);

   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   state_t              state;
   logic [CNT_W-1:0]    count;
   logic [CNT_W-1:0]    bit_idx;
   logic [MAX_BITS-1:0] shift;
   logic [CNT_W-1:0]    last_idx;
   logic                fall;
   logic                stop_bit;

   bclk_edge u_bclk_edge (
      .i_Pclk  (i_Pclk),
      .i_Reset (i_Reset),
      .i_Bclk  (i_Bclk),
      .o_Fall  (fall)
   );

   assign last_idx = count - CNT_ONE;

   always_comb begin
      stop_bit = 1'b0;
      for (int i = 0; i < int'(MAX_BITS); i++) begin
         if (CNT_W'(i) == last_idx)
            stop_bit = shift[i];
      end
   end

`ifdef RXDEFRAMER_PARITY_EN
   logic par_sum;

   // XOR over data and parity bits, i.e. indices 1 .. count-2.
   always_comb begin
      par_sum = 1'b0;
      for (int i = 1; i < int'(MAX_BITS); i++) begin
         if (CNT_W'(i) < last_idx)
            par_sum = par_sum ^ shift[i];
      end
   end
`endif

   always_ff @(posedge i_Pclk) begin
      if (i_Reset) begin
         state       <= IDLE;
         count       <= '0;
         bit_idx     <= '0;
         shift       <= '0;
         o_Valid     <= 1'b0;
         o_Data      <= '0;
         o_Frame_Err <= 1'b0;
`ifdef RXDEFRAMER_PARITY_EN
         o_Parity_Err <= 1'b0;
`endif
         o_Overrun   <= 1'b0;
         o_Busy      <= 1'b0;
      end else begin
         if (o_Valid && i_Ready)
            o_Valid <= 1'b0;

         case (state)
            IDLE: begin
               if (i_Enable && !i_Rx_Serial) begin
                  state   <= RECV;
                  o_Busy  <= 1'b1;
                  count   <= CNT_W'(clamp_count(32'(i_Count), MAX_BITS));
                  bit_idx <= '0;
                  shift   <= '0;
               end
            end

            RECV: begin
               if (fall) begin
                  for (int i = 0; i < int'(MAX_BITS); i++) begin
                     if (CNT_W'(i) == bit_idx)
                        shift[i] <= i_Rx_Serial;
                  end
                  bit_idx <= bit_idx + CNT_ONE;
                  // A start bit that reads high at its sampling point was noise.
                  if (bit_idx == '0 && i_Rx_Serial) begin
                     state  <= IDLE;
                     o_Busy <= 1'b0;
                  end else if (bit_idx == last_idx) begin
                     state <= COMMIT;
                  end
               end
            end

            COMMIT: begin
               if (!o_Valid || i_Ready) begin
                  o_Valid     <= 1'b1;
                  o_Data      <= shift;
                  o_Frame_Err <= ~stop_bit;
`ifdef RXDEFRAMER_PARITY_EN
                  o_Parity_Err <= (par_sum != i_Parity_Odd);
`endif
               end else begin
                  o_Overrun <= 1'b1;
               end
               state  <= IDLE;
               o_Busy <= 1'b0;
            end

            default: begin
               state  <= IDLE;
               o_Busy <= 1'b0;
            end
         endcase
      end
   end

endmodule
